aes_encoder: RTL and testbench
==============================

AES_ENCODER -- requirements
Module: aes_encoder

Interface
REQ-001 Parameter KEY_SIZE, default 128, cipher key width in bits; legal values 128, 192, 256; any other value SHALL fail elaboration.
REQ-002 Derived constant NUM_ROUNDS SHALL be 10, 12 or 14 for KEY_SIZE 128, 192 or 256 respectively.
REQ-003 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 plain  input  128  plaintext block, FIPS-197 input byte 0 in bits [127:120] through byte 15 in bits [7:0]; sampled every cycle.
REQ-006 key  input  KEY_SIZE  cipher key, key byte 0 in the MSBs; sampled every cycle together with plain.
REQ-007 encrypted  output  128  ciphertext, same byte order as plain.
REQ-008 valid  output  1  high when encrypted holds a ciphertext computed from a post-reset input pair.

Function
REQ-009 The block SHALL implement the FIPS-197 cipher: initial AddRoundKey, then NUM_ROUNDS-1 full rounds (SubBytes, ShiftRows, MixColumns, AddRoundKey), then a final round without MixColumns.
REQ-010 The block SHALL be fully pipelined with exactly NUM_ROUNDS register stages, accepting a new plain/key pair every cycle with no stall or back-pressure.
REQ-011 Latency SHALL be exactly NUM_ROUNDS rising edges: a pair sampled at edge t SHALL produce its ciphertext on encrypted immediately after edge t+NUM_ROUNDS-1, visible when sampled at edge t+NUM_ROUNDS.
REQ-012 Stage 1 SHALL register the result of the initial AddRoundKey plus round 1; stage r SHALL register round r; stage NUM_ROUNDS SHALL drive encrypted directly, with no combinational logic after it.
REQ-013 The cipher key SHALL travel down the pipeline alongside its data, one key register per stage. Each stage SHALL derive its round key from its own carried key per FIPS-197 key expansion, so consecutive blocks may use different keys.
REQ-014 A valid shift register of NUM_ROUNDS bits SHALL shift in 1 each edge after reset release; valid SHALL be its last bit, first high NUM_ROUNDS edges after the first post-reset edge.
REQ-015 Once high, valid SHALL stay high until the next reset assertion.
REQ-016 Data and key are unqualified: any plain or key value, including all-zero, SHALL be encrypted identically.

Reset
REQ-017 While reset is low, all data, key and valid registers SHALL clear asynchronously; encrypted SHALL read 0 and valid SHALL read 0.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight blocks; after release, the sequence SHALL restart exactly per REQ-014.
REQ-019 Reset release SHALL be synchronised by the driver to avoid recovery violations; no internal synchroniser SHALL be added.

Configuration
REQ-020 With macro AES_ENCODER_SBOX_ROM_EN defined, SubBytes SHALL use a 256-entry constant lookup table.
REQ-021 Without AES_ENCODER_SBOX_ROM_EN, SubBytes SHALL be computed as GF(2^8) multiplicative inverse followed by the FIPS-197 affine transform.
REQ-022 Both builds SHALL be cycle- and bit-identical at the ports.

Verification
REQ-023 KEY_SIZE=128; key 000102030405060708090a0b0c0d0e0f; plain 00112233445566778899aabbccddeeff -> encrypted 69c4e0d86a7b0430d8cdb78070b4c55a exactly 10 edges later, valid=1.
REQ-024 KEY_SIZE=128; key 2b7e151628aed2a6abf7158809cf4f3c; plain 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
REQ-025 KEY_SIZE=192 with key 000102...17, and KEY_SIZE=256 with key 000102...1f, plain 00112233...eeff -> dda97ca4864cdfe06eaf70a0ec0d7191 after 12 edges and 8ea2b7ca516745bfeafc49904b496089 after 14 edges respectively.
REQ-026 Back-to-back stream: vectors of REQ-023 and REQ-024 alternated every cycle, including key changes, for 300 cycles -> each ciphertext correct and aligned exactly NUM_ROUNDS edges after its input, with no gaps.
REQ-027 Reset pulsed low for 1 cycle mid-stream -> encrypted=0 and valid=0 immediately; valid low for exactly NUM_ROUNDS edges after release, then correct results resume.
REQ-028 Repeat REQ-023 through REQ-027 with and without AES_ENCODER_SBOX_ROM_EN -> identical port traces.

Source files
------------

// File: rtl/aes_encoder.sv
// aes_encoder: fully pipelined AES cipher, one round per register stage.
// Throughput is one plain/key pair per clock. Each key travels through the
// pipeline with its own block, so consecutive blocks may use different keys.
// Optional build macro: AES_ENCODER_SBOX_ROM_EN selects a 256-entry S-box table.
// Without it, the S-box is computed as the GF(2^8) inverse followed by the affine map.
module aes_encoder #(
  parameter int unsigned KEY_SIZE = 128
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [127:0]        plain,
  input  logic [KEY_SIZE-1:0] key,
  output logic [127:0]        encrypted,
  output logic                valid
);

  localparam int unsigned NK         = KEY_SIZE / 32;
  localparam int unsigned NUM_ROUNDS = NK + 6;

  if (KEY_SIZE != 128 && KEY_SIZE != 192 && KEY_SIZE != 256) begin : g_bad_key_size
    $error("aes_encoder: KEY_SIZE must be 128, 192 or 256");
  end

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

`ifdef AES_ENCODER_SBOX_ROM_EN
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // S-box by table lookup
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction
`else
  // GF(2^8) multiply, shift-and-add
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // S-box as x^254 (inverse, with 0 -> 0) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
`endif

  // SubBytes over all 16 state bytes
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // ShiftRows: byte (row r, column c) sits at state byte 4c+r, byte 0 in the MSBs
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  // MixColumns on each 32-bit column
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // One cipher round; the final round omits MixColumns
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] t;
    t = shift_rows(sub_bytes(s));
    if (!last) t = mix_columns(t);
    return t ^ rk;
  endfunction

  // Round constant for key-expansion step j (j >= 1)
  function automatic logic [7:0] rcon(input int unsigned j);
    logic [7:0] r;
    r = 8'h01;
    for (int unsigned k = 1; k < 16; k++) begin
      if (k < j) r = xtime(r);
    end
    return r;
  endfunction

  // SubWord on four bytes
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Advance the NK-word key-schedule window by count words, starting at word index first_idx.
  // The oldest word sits in the MSBs, so w[i-NK] is the top word and w[i-1] the bottom word.
  function automatic logic [KEY_SIZE-1:0] next_window(input logic [KEY_SIZE-1:0] win,
                                                      input int unsigned first_idx,
                                                      input int unsigned count);
    logic [KEY_SIZE-1:0] w;
    logic [31:0]         temp;
    int unsigned         idx;
    w = win;
    for (int unsigned k = 0; k < 4; k++) begin
      if (k < count) begin
        idx  = first_idx + k;
        temp = w[31:0];
        if (idx % NK == 0) begin
          temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon(idx / NK), 24'h000000};
        end else if (NK > 6 && idx % NK == 4) begin
          temp = sub_word(temp);
        end
        w = {w[KEY_SIZE-33:0], w[KEY_SIZE-1 -: 32] ^ temp};
      end
    end
    return w;
  endfunction

  // Round key for a stage: the newest four words of its advanced window
  function automatic logic [127:0] round_key(input logic [KEY_SIZE-1:0] win,
                                             input int unsigned first_idx,
                                             input int unsigned count);
    logic [KEY_SIZE-1:0] w;
    w = next_window(win, first_idx, count);
    return w[127:0];
  endfunction

  // Stage r+1 computes cipher round r+1. Stage 1 also applies the initial AddRoundKey.
  // Stage 1 generates only the words that round key 1 still needs (8-NK of them);
  // later stages each generate four words. The last stage's key window feeds nothing
  // downstream, so no key register follows it.
  for (genvar r = 0; r < NUM_ROUNDS; r++) begin : g_stage
    localparam int unsigned FIRST = (r == 0) ? NK : 32'(4 * (r + 1));
    localparam int unsigned COUNT = (r == 0) ? 8 - NK : 4;
    localparam bit          LAST  = (r == NUM_ROUNDS - 1);

    logic [KEY_SIZE-1:0] src_c;
    logic [127:0]        data_in_c;
    logic [127:0]        rk_c;
    logic [127:0]        data_q;

    if (r == 0) begin : g_first
      assign src_c     = key;
      assign data_in_c = plain ^ key[KEY_SIZE-1 -: 128];
    end else begin : g_next
      assign src_c     = g_stage[r-1].g_key.key_q;
      assign data_in_c = g_stage[r-1].data_q;
    end

    assign rk_c = round_key(src_c, FIRST, COUNT);

    // Round data register
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) data_q <= '0;
      else        data_q <= aes_round(data_in_c, rk_c, LAST);
    end

    if (r < NUM_ROUNDS - 1) begin : g_key
      logic [KEY_SIZE-1:0] key_q;

      // Key-schedule window travelling with this stage's block
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) key_q <= '0;
        else        key_q <= next_window(src_c, FIRST, COUNT);
      end
    end
  end

  logic [NUM_ROUNDS-1:0] vld_q;

  // Valid shift register: fills with ones after reset release
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) vld_q <= '0;
    else        vld_q <= {vld_q[NUM_ROUNDS-2:0], 1'b1};
  end

  assign encrypted = g_stage[NUM_ROUNDS-1].data_q;
  assign valid     = vld_q[NUM_ROUNDS-1];

endmodule

// File: tb/tb_aes_encoder.sv
// tb_aes_encoder: directed-vector bench for aes_encoder at all three key sizes.
module tb_aes_encoder;

  localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clock;
  logic         reset;
  logic [127:0] plain;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic [127:0] enc128, enc192, enc256;
  logic         v128, v192, v256;

  int total = 0;
  int bad   = 0;

  aes_encoder #(.KEY_SIZE(128)) dut128 (
    .clock(clock), .reset(reset), .plain(plain), .key(key128),
    .encrypted(enc128), .valid(v128));
  aes_encoder #(.KEY_SIZE(192)) dut192 (
    .clock(clock), .reset(reset), .plain(plain), .key(key192),
    .encrypted(enc192), .valid(v192));
  aes_encoder #(.KEY_SIZE(256)) dut256 (
    .clock(clock), .reset(reset), .plain(plain), .key(key256),
    .encrypted(enc256), .valid(v256));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset;
    reset  = 1'b0;
    plain  = '0;
    key128 = '0;
    key192 = '0;
    key256 = '0;
    repeat (3) @(posedge clock);
    #1;
    total++; if (enc128 !== 128'h0) begin bad++; $display("FAIL reset_enc128: got %h want 0", enc128); end
    total++; if (enc192 !== 128'h0) begin bad++; $display("FAIL reset_enc192: got %h want 0", enc192); end
    total++; if (enc256 !== 128'h0) begin bad++; $display("FAIL reset_enc256: got %h want 0", enc256); end
    total++; if (v128 !== 1'b0) begin bad++; $display("FAIL reset_v128: got %b want 0", v128); end
    total++; if (v192 !== 1'b0) begin bad++; $display("FAIL reset_v192: got %b want 0", v192); end
    total++; if (v256 !== 1'b0) begin bad++; $display("FAIL reset_v256: got %b want 0", v256); end
    reset = 1'b1;
  endtask

  task automatic test_valid_ramp;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clock); #1;
      total++;
      if (v128 !== (k >= 10)) begin bad++; $display("FAIL ramp_v128 edge %0d: got %b want %b", k, v128, k >= 10); end
      total++;
      if (v192 !== (k >= 12)) begin bad++; $display("FAIL ramp_v192 edge %0d: got %b want %b", k, v192, k >= 12); end
      total++;
      if (v256 !== (k >= 14)) begin bad++; $display("FAIL ramp_v256 edge %0d: got %b want %b", k, v256, k >= 14); end
    end
  endtask

  task automatic test_fips128;
    logic [127:0] want;
    for (int v = 0; v < 2; v++) begin
      plain  = (v == 0) ? PA : PB;
      key128 = (v == 0) ? KA : KB;
      want   = (v == 0) ? CA : CB;
      for (int e = 1; e <= 11; e++) begin
        @(posedge clock); #1;
        if (e == 1) begin
          plain  = '0;
          key128 = '0;
        end
        if (e == 9) begin
          total++;
          if (enc128 !== CZ) begin bad++; $display("FAIL fips128_pre vec %0d: got %h want %h", v, enc128, CZ); end
        end
        if (e == 10) begin
          total++;
          if (enc128 !== want) begin bad++; $display("FAIL fips128 vec %0d: got %h want %h", v, enc128, want); end
          total++;
          if (v128 !== 1'b1) begin bad++; $display("FAIL fips128_valid vec %0d: got %b want 1", v, v128); end
        end
        if (e == 11) begin
          total++;
          if (enc128 !== CZ) begin bad++; $display("FAIL fips128_post vec %0d: got %h want %h", v, enc128, CZ); end
        end
      end
    end
  endtask

  task automatic test_fips192_256;
    plain  = PA;
    key192 = K192;
    key256 = K256;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clock); #1;
      if (e == 1) begin
        plain  = '0;
        key192 = '0;
        key256 = '0;
      end
      if (e == 11 || e == 13) begin
        total++;
        if (enc192 === C192) begin bad++; $display("FAIL fips192_early edge %0d: got %h want not %h", e, enc192, C192); end
      end
      if (e == 12) begin
        total++;
        if (enc192 !== C192) begin bad++; $display("FAIL fips192: got %h want %h", enc192, C192); end
        total++;
        if (v192 !== 1'b1) begin bad++; $display("FAIL fips192_valid: got %b want 1", v192); end
      end
      if (e == 13 || e == 15) begin
        total++;
        if (enc256 === C256) begin bad++; $display("FAIL fips256_early edge %0d: got %h want not %h", e, enc256, C256); end
      end
      if (e == 14) begin
        total++;
        if (enc256 !== C256) begin bad++; $display("FAIL fips256: got %h want %h", enc256, C256); end
        total++;
        if (v256 !== 1'b1) begin bad++; $display("FAIL fips256_valid: got %b want 1", v256); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] want;
    for (int c = 0; c < 310; c++) begin
      if (c < 300) begin
        plain  = (c % 2 == 0) ? PA : PB;
        key128 = (c % 2 == 0) ? KA : KB;
      end else begin
        plain  = '0;
        key128 = '0;
      end
      @(posedge clock); #1;
      if (c >= 9) begin
        if (c - 9 >= 300) want = CZ;
        else              want = ((c - 9) % 2 == 0) ? CA : CB;
        total++;
        if (enc128 !== want) begin bad++; $display("FAIL stream cycle %0d: got %h want %h", c, enc128, want); end
        total++;
        if (v128 !== 1'b1) begin bad++; $display("FAIL stream_valid cycle %0d: got %b want 1", c, v128); end
      end
    end
  endtask

  task automatic test_reset_mid_stream;
    for (int c = 0; c < 20; c++) begin
      plain  = (c % 2 == 0) ? PA : PB;
      key128 = (c % 2 == 0) ? KA : KB;
      @(posedge clock); #1;
    end
    total++;
    if (v128 !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid: got %b want 1", v128); end
    reset = 1'b0;
    #1;
    total++; if (enc128 !== 128'h0) begin bad++; $display("FAIL midrst_enc128: got %h want 0", enc128); end
    total++; if (v128 !== 1'b0) begin bad++; $display("FAIL midrst_v128: got %b want 0", v128); end
    total++; if (v192 !== 1'b0) begin bad++; $display("FAIL midrst_v192: got %b want 0", v192); end
    total++; if (enc256 !== 128'h0) begin bad++; $display("FAIL midrst_enc256: got %h want 0", enc256); end
    @(posedge clock); #1;
    total++; if (enc128 !== 128'h0) begin bad++; $display("FAIL midrst_hold_enc128: got %h want 0", enc128); end
    reset = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      plain  = (k % 2 == 1) ? PA : PB;
      key128 = (k % 2 == 1) ? KA : KB;
      @(posedge clock); #1;
      if (k < 10) begin
        total++;
        if (v128 !== 1'b0) begin bad++; $display("FAIL midrst_refill_valid edge %0d: got %b want 0", k, v128); end
      end
      if (k == 10) begin
        total++;
        if (v128 !== 1'b1) begin bad++; $display("FAIL midrst_resume_valid: got %b want 1", v128); end
        total++;
        if (enc128 !== CA) begin bad++; $display("FAIL midrst_resume_a: got %h want %h", enc128, CA); end
      end
      if (k == 11) begin
        total++;
        if (enc128 !== CB) begin bad++; $display("FAIL midrst_resume_b: got %h want %h", enc128, CB); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_valid_ramp();
    test_fips128();
    test_fips192_256();
    test_back_to_back();
    test_reset_mid_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
